axi_rd_arbiter: RTL and testbench

- Shares one AXI read master port between the instruction-cache refill path and the data-cache refill path.
- Accepts one burst request per requester, arbitrates, and issues a single AR transaction.
- Steers the returning R beats to the owning requester and holds ownership until RLAST.
- Sits between the L1 instruction/data caches and the bus, so the CPU exposes a single read master.

---
 rtl/axi_rd_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter
//
// Purpose: shares a single AXI read master between the instruction-cache and
// data-cache refill paths. Each side raises one burst request. The arbiter
// grants one of them in IDLE and issues a single AR transaction. It then steers
// the returning R beats to the owner and keeps ownership until the owner's
// RLAST.
//
// Optional feature: define ARB_RR_EN for round-robin arbitration. This uses a
// 1-bit last_owner register that resets to the instruction side. When the macro
// is absent, the data side has fixed priority over the instruction side.
//
// Ports:
//   ACLK, ARESETn                 clock, asynchronous active-low reset
//   i_req/i_addr/i_len            instruction-side burst request (level)
//   i_gnt                         one-cycle accept pulse to instruction side
//   i_rdata/i_rvalid/i_rlast      beats steered to instruction side
//   d_*                           data-side equivalents
//   AR* / R*                      AXI read address / read data channels
//   busy                          arbiter owns the bus (not IDLE)
//   err                           one-cycle protocol-error pulse
// -----------------------------------------------------------------------------
module axi_rd_arbiter #(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32,
    parameter int         LEN_W  = 4,
    parameter logic [3:0] ID_I   = 4'd1,
    parameter logic [3:0] ID_D   = 4'd2
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LEN_W-1:0]  i_len,
    output logic              i_gnt,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_rlast,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LEN_W-1:0]  d_len,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_rlast,
    output logic [3:0]        ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [LEN_W-1:0]  ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [3:0]        RID,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    output logic              busy,
    output logic              err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]        state_q,   state_d;
    logic [ADDR_W-1:0] araddr_q,  araddr_d;
    logic [LEN_W-1:0]  arlen_q,   arlen_d;
    logic [3:0]        arid_q,    arid_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q,  rready_d;
    logic              owner_q,   owner_d;   // 1 = data side owns the burst
    logic [LEN_W-1:0]  cnt_q,     cnt_d;
    logic              done_q,    done_d;    // len-th beat already delivered

    logic grant;
    logic pick_d;
    logic beat_acc;
    logic id_ok;
    logic at_len;
    logic fwd;
    logic rlast_fwd;

    // Arbitration: decide which side wins when this is an IDLE cycle.
`ifdef ARB_RR_EN
    logic last_owner_q, last_owner_d;    // 1 = data side took the previous grant

    // On a tie, the side that did not take the previous grant wins.
    assign pick_d = d_req & (~i_req | ~last_owner_q);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            last_owner_q <= 1'b0;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        last_owner_d = last_owner_q;
        if (grant) begin
            last_owner_d = pick_d;
        end
    end
`else
    assign pick_d = d_req;
`endif

    assign grant = (state_q == S_IDLE) & (i_req | d_req);
    assign i_gnt = grant & ~pick_d;
    assign d_gnt = grant & pick_d;

    // Beat qualification. The counter stops at len, so done_q marks that the
    // overrun beats are being drained after the owner's forced rlast.
    assign beat_acc  = (state_q == S_DATA) & rready_q & RVALID;
    assign id_ok     = (RID == arid_q);
    assign at_len    = (cnt_q == arlen_q);
    assign fwd       = beat_acc & id_ok & ~done_q;
    assign rlast_fwd = RLAST | at_len;

    assign i_rvalid = fwd & ~owner_q;
    assign d_rvalid = fwd &  owner_q;
    assign i_rlast  = i_rvalid & rlast_fwd;
    assign d_rlast  = d_rvalid & rlast_fwd;
    assign i_rdata  = i_rvalid ? RDATA : '0;
    assign d_rdata  = d_rvalid ? RDATA : '0;

    assign err = beat_acc & (~id_ok
                             | (RRESP != 2'b00)
                             | (~done_q & RLAST & ~at_len)
                             | (~done_q & ~RLAST & at_len));

    assign ARID    = arid_q;
    assign ARADDR  = araddr_q;
    assign ARLEN   = arlen_q;
    assign ARVALID = arvalid_q;
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;
    assign RREADY  = rready_q;
    assign busy    = (state_q != S_IDLE);

    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arid_d    = arid_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    araddr_d  = pick_d ? d_addr : i_addr;
                    arlen_d   = pick_d ? d_len  : i_len;
                    arid_d    = pick_d ? ID_D   : ID_I;
                    owner_d   = pick_d;
                    arvalid_d = 1'b1;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    cnt_d     = '0;
                    done_d    = 1'b0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (fwd) begin
                    if (at_len) begin
                        done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
                // Only the owner's own RLAST ends the burst; a foreign-ID beat
                // is swallowed without affecting ownership.
                if (beat_acc & id_ok & RLAST) begin
                    rready_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= S_IDLE;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arid_q    <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            owner_q   <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arid_q    <= arid_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        i_req, d_req;
    logic [31:0] i_addr, d_addr;
    logic [3:0]  i_len, d_len;
    logic        i_gnt, d_gnt;
    logic [31:0] i_rdata, d_rdata;
    logic        i_rvalid, d_rvalid, i_rlast, d_rlast;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID, ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST, RVALID, RREADY;
    logic        busy, err;

    int tests = 0;
    int fails = 0;
    bit lo_m;   // reference: 1 when data side took the previous grant

    always #5 ACLK = ~ACLK;

    axi_rd_arbiter dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_gnt(i_gnt),
        .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rlast(i_rlast),
        .d_req(d_req), .d_addr(d_addr), .d_len(d_len), .d_gnt(d_gnt),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rlast(d_rlast),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY), .busy(busy), .err(err)
    );

    // Reference arbitration rule: a lone requester always wins; on a tie the
    // data side wins (fixed) or the side that did not win last time (RR).
    function automatic bit model_pick_d(input bit ir, input bit dr);
        if (!dr) return 1'b0;
        if (!ir) return 1'b1;
`ifdef ARB_RR_EN
        return (lo_m == 1'b0);
`else
        return 1'b1;
`endif
    endfunction

    task automatic next_cycle();
        @(posedge ACLK);
        #1;
    endtask

    // Serves one granted burst, beginning with the IDLE cycle in which the
    // caller has already raised the request lines.
    // kind: 0 normal, 1 RRESP error on beat k, 2 early RLAST on beat k,
    //       3 foreign-ID beat inserted before beat k, 4 k extra beats past len.
    task automatic run_burst(input int ar_wait, input int kind, input int k);
        bit          wd, fw, e_last, e_err, ov, ol, oth;
        logic [31:0] ea, od;
        logic [3:0]  el, eid;
        int          nb, gap;
        wd  = model_pick_d(i_req, d_req);
        ea  = wd ? d_addr : i_addr;
        el  = wd ? d_len  : i_len;
        eid = wd ? 4'd2   : 4'd1;
        @(negedge ACLK);
        tests++;
        if ({i_gnt, d_gnt, busy, ARVALID} !== {~wd, wd, 1'b0, 1'b0})
            $display("FAIL grant: i_gnt,d_gnt,busy,ARVALID=%b expected %b",
                     {i_gnt, d_gnt, busy, ARVALID}, {~wd, wd, 1'b0, 1'b0});
        if ({i_gnt, d_gnt, busy, ARVALID} !== {~wd, wd, 1'b0, 1'b0}) fails++;
        lo_m = wd;
        next_cycle();
        if (wd) d_req = 1'b0; else i_req = 1'b0;
        for (int w = 0; w <= ar_wait; w++) begin
            ARREADY = (w == ar_wait);
            @(negedge ACLK);
            tests++;
            if ({ARVALID, ARADDR, ARLEN, ARID, busy, i_gnt, d_gnt} !==
                {1'b1, ea, el, eid, 1'b1, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL ar_phase: ARVALID=%b ARADDR=%h ARLEN=%0d ARID=%0d gnt=%b%b, expected 1 %h %0d %0d 00",
                         ARVALID, ARADDR, ARLEN, ARID, i_gnt, d_gnt, ea, el, eid);
            end
            next_cycle();
        end
        ARREADY = 1'b0;
        nb = (kind == 2) ? k + 1 : (kind == 4) ? int'(el) + 1 + k : int'(el) + 1;
        for (int j = 0; j < nb; j++) begin
            if (kind == 3 && j == k) begin
                RVALID = 1'b1; RID = 4'd7; RDATA = $urandom; RRESP = 2'b00; RLAST = 1'b0;
                @(negedge ACLK);
                tests++;
                if ({RREADY, i_rvalid, d_rvalid, err} !== 4'b1001) begin
                    fails++;
                    $display("FAIL foreign_id: RREADY,i_rvalid,d_rvalid,err=%b expected 1001",
                             {RREADY, i_rvalid, d_rvalid, err});
                end
                next_cycle();
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
                @(negedge ACLK);
                tests++;
                if ({RREADY, busy, i_rvalid, d_rvalid, err} !== 5'b11000) begin
                    fails++;
                    $display("FAIL r_gap: RREADY,busy,i_rvalid,d_rvalid,err=%b expected 11000",
                             {RREADY, busy, i_rvalid, d_rvalid, err});
                end
                next_cycle();
            end
            RVALID = 1'b1;
            RID    = eid;
            RDATA  = $urandom;
            RRESP  = (kind == 1 && j == k) ? 2'b10 : 2'b00;
            RLAST  = (j == nb - 1);
            fw     = (j <= int'(el));
            e_last = fw && (RLAST || j == int'(el));
            e_err  = (RRESP != 2'b00) || (fw && RLAST && j < int'(el)) ||
                     (fw && !RLAST && j == int'(el));
            @(negedge ACLK);
            ov  = wd ? d_rvalid : i_rvalid;
            ol  = wd ? d_rlast  : i_rlast;
            od  = wd ? d_rdata  : i_rdata;
            oth = wd ? i_rvalid : d_rvalid;
            tests++;
            if ({RREADY, ov, ol, oth, err} !== {1'b1, fw, e_last, 1'b0, e_err} ||
                od !== (fw ? RDATA : 32'h0)) begin
                fails++;
                $display("FAIL beat%0d: RREADY,rvalid,rlast,other_rvalid,err=%b data=%h expected %b data=%h",
                         j, {RREADY, ov, ol, oth, err}, od,
                         {1'b1, fw, e_last, 1'b0, e_err}, fw ? RDATA : 32'h0);
            end
            next_cycle();
        end
        RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
    endtask

    task automatic idle_check(input string nm);
        @(negedge ACLK);
        tests++;
        if ({busy, RREADY, ARVALID, i_gnt, d_gnt, i_rvalid, d_rvalid, err} !== 8'b0) begin
            fails++;
            $display("FAIL %s: busy,RREADY,ARVALID,gnt,rvalid,err=%b expected 00000000",
                     nm, {busy, RREADY, ARVALID, i_gnt, d_gnt, i_rvalid, d_rvalid, err});
        end
        next_cycle();
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        i_req = 0; d_req = 0; i_addr = 0; d_addr = 0; i_len = 0; d_len = 0;
        ARREADY = 0; RID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RVALID = 0;
        lo_m = 1'b0;
        @(negedge ACLK);
        tests++;
        if ({busy, RREADY, ARVALID, ARID, ARADDR, ARLEN, err, i_gnt, d_gnt, i_rvalid, d_rvalid} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b RREADY=%b ARVALID=%b ARID=%h ARADDR=%h expected all 0",
                     busy, RREADY, ARVALID, ARID, ARADDR);
        end
        tests++;
        if ({ARSIZE, ARBURST} !== 5'b010_01) begin
            fails++;
            $display("FAIL ar_const: ARSIZE,ARBURST=%b expected 01001", {ARSIZE, ARBURST});
        end
        next_cycle();
        ARESETn = 1'b1;
        idle_check("idle_after_reset");
    endtask

    task automatic test_single_i();
        i_req = 1; i_addr = 32'h0000_1000; i_len = 4'd3;
        run_burst(2, 0, 0);
        idle_check("single_i_end");
    endtask

    task automatic test_simultaneous();
        // Tie from a clean state, then back-to-back service of the loser.
        i_req = 1; i_addr = 32'h0000_3000; i_len = 4'd1;
        d_req = 1; d_addr = 32'h0000_2000; d_len = 4'd0;
        run_burst(0, 0, 0);
        run_burst(1, 0, 0);
        idle_check("simul_end1");
        // After a data-side grant, a tie goes to instruction side under RR.
        d_req = 1; d_addr = 32'h0000_2400; d_len = 4'd1;
        run_burst(0, 0, 0);
        i_req = 1; i_addr = 32'h0000_5000; i_len = 4'd2;
        d_req = 1; d_addr = 32'h0000_2000; d_len = 4'd0;
        run_burst(0, 0, 0);
        run_burst(0, 0, 0);
        idle_check("simul_end2");
    endtask

    task automatic test_rresp_err();
        i_req = 1; i_addr = 32'h0000_1100; i_len = 4'd3;
        run_burst(0, 1, 1);
        idle_check("rresp_end");
    endtask

    task automatic test_early_last();
        i_req = 1; i_addr = 32'h0000_1200; i_len = 4'd3;
        run_burst(1, 2, 1);
        idle_check("early_last_end");
    endtask

    task automatic test_bad_rid();
        d_req = 1; d_addr = 32'h0000_2200; d_len = 4'd3;
        run_burst(0, 3, 1);
        idle_check("bad_rid_end");
    endtask

    task automatic test_overrun();
        d_req = 1; d_addr = 32'h0000_2300; d_len = 4'd2;
        run_burst(0, 4, 2);
        idle_check("overrun_end");
    endtask

    task automatic test_random();
        int sel, kind, k, lw;
        bit both;
        for (int n = 0; n < 25; n++) begin
            sel = $urandom_range(0, 2);
            i_addr = $urandom & 32'hFFFF_FFC0; i_len = 4'($urandom_range(0, 15));
            d_addr = $urandom & 32'hFFFF_FFC0; d_len = 4'($urandom_range(0, 15));
            i_req = (sel != 1); d_req = (sel != 0);
            both = (sel == 2);
            for (int r = 0; r < (both ? 2 : 1); r++) begin
                lw = model_pick_d(i_req, d_req) ? int'(d_len) : int'(i_len);
                kind = $urandom_range(0, 4);
                if (kind == 2 && lw == 0) kind = 0;
                k = (kind == 2) ? $urandom_range(0, lw - 1) :
                    (kind == 4) ? $urandom_range(1, 2) : $urandom_range(0, lw);
                run_burst($urandom_range(0, 3), kind, k);
            end
        end
        idle_check("random_end");
    endtask

    task automatic test_reset_mid();
        i_req = 1; i_addr = 32'h0000_1800; i_len = 4'd3;
        @(negedge ACLK);
        lo_m = 1'b0;
        next_cycle();
        i_req = 0; ARREADY = 1;
        @(negedge ACLK);
        next_cycle();
        ARREADY = 0;
        RVALID = 1; RID = 4'd1; RDATA = 32'hA5A5_0001; RLAST = 0; RRESP = 0;
        @(negedge ACLK);
        tests++;
        if (i_rvalid !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_beat: i_rvalid=%b expected 1", i_rvalid);
        end
        next_cycle();
        RDATA = 32'hA5A5_0002;
        #1 ARESETn = 1'b0;
        #1;
        tests++;
        if ({i_rvalid, d_rvalid, i_rlast, i_rdata, RREADY, busy, ARVALID, ARADDR, ARID, err} !== '0) begin
            fails++;
            $display("FAIL mid_reset: i_rvalid=%b i_rdata=%h RREADY=%b busy=%b ARVALID=%b ARADDR=%h expected all 0",
                     i_rvalid, i_rdata, RREADY, busy, ARVALID, ARADDR);
        end
        lo_m = 1'b0;
        next_cycle();
        ARESETn = 1'b1;
        @(negedge ACLK);
        tests++;
        if ({i_rvalid, d_rvalid, RREADY, busy, err} !== 5'b0) begin
            fails++;
            $display("FAIL stale_after_reset: i_rvalid,d_rvalid,RREADY,busy,err=%b expected 00000",
                     {i_rvalid, d_rvalid, RREADY, busy, err});
        end
        next_cycle();
        RVALID = 0;
        i_req = 1; i_addr = 32'h0000_1900; i_len = 4'd1;
        run_burst(0, 0, 0);
        idle_check("post_reset_end");
    endtask

    initial begin
        test_reset();
        test_single_i();
        test_simultaneous();
        test_rresp_err();
        test_early_last();
        test_bad_rid();
        test_overrun();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
